gs_window_ctrl: RTL

//  Sequencer for the 3x3 line-buffer/window filter datapath (Gaussian and similar stages).

---
 rtl/gs_window_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/gs_window_ctrl.sv
// ============================================================================
// Module  : gs_window_ctrl
// Brief   : Frame sequencer for a 3x3 line-buffer window filter.
//           Drives the shift-register clock enable, runs the end-of-frame flush
//           and tags the window-centre pixel.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gs_window_ctrl #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CW    = 10,
    parameter int RW    = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          din_sop,
    input  logic          din_eop,
    input  logic          din_vld,
    input  logic [7:0]    din,
    output logic          din_rdy,
    output logic          win_en,
    output logic [7:0]    win_din,
    output logic          ctr_vld,
    output logic          ctr_sop,
    output logic          ctr_eop,
    output logic          ctr_border,
    output logic [CW-1:0] ctr_col,
    output logic [RW-1:0] ctr_row,
    output logic          busy,
    output logic [2:0]    err,
    input  logic          err_clr
);

    localparam int c_NPIX  = IMG_W * IMG_H;
    localparam int c_KLAST = c_NPIX + IMG_W;
    localparam int KW      = $clog2(c_KLAST + 1);

    localparam logic [KW-1:0] c_K_PIXLAST = KW'(c_NPIX - 1);
    localparam logic [KW-1:0] c_K_CTR0    = KW'(IMG_W + 1);
    localparam logic [KW-1:0] c_K_LAST    = KW'(c_KLAST);
    localparam logic [CW-1:0] c_COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] c_ROW_LAST  = RW'(IMG_H - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [KW-1:0] r_k;
    logic [CW-1:0] r_ncol;
    logic [RW-1:0] r_nrow;
    logic [2:0]    r_err;
    logic          r_win_en;
    logic [7:0]    r_win_din;
    logic          r_ctr_vld;
    logic          r_ctr_sop;
    logic          r_ctr_eop;
    logic          r_ctr_border;
    logic [CW-1:0] r_ctr_col;
    logic [RW-1:0] r_ctr_row;

    logic          w_accept;
    logic          w_issue;
    logic [KW-1:0] w_kcur;
    logic [KW-1:0] w_kiss;
    logic          w_cvld;
    logic          w_set_sop;
    logic          w_set_len;
    logic          w_set_ovf;

    // r_k holds the index the next win_en will carry; an accepted sop restarts at 0.
    assign w_accept = din_vld & (((r_state == S_IDLE) & din_sop) | (r_state == S_ACTIVE));
    assign w_issue  = w_accept | (r_state == S_FLUSH);
    assign w_kcur   = din_sop ? '0 : r_k;
    assign w_kiss   = w_accept ? w_kcur : r_k;
    assign w_cvld   = w_issue & (w_kiss >= c_K_CTR0) & (w_kiss <= c_K_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_set_sop   = 1'b0;
        w_set_len   = 1'b0;
        w_set_ovf   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = din_eop ? S_IDLE : S_ACTIVE;
                    w_set_len   = din_eop;
                end
            end
            S_ACTIVE: begin
                if (w_accept) begin
                    w_set_sop = din_sop & (r_k != '0);
                    if (din_eop) begin
                        w_state_nxt = (w_kcur == c_K_PIXLAST) ? S_FLUSH : S_IDLE;
                        w_set_len   = (w_kcur != c_K_PIXLAST);
                    end else if (w_kcur == c_K_PIXLAST) begin
                        w_state_nxt = S_FLUSH;
                        w_set_len   = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                w_set_ovf = din_vld;
                if (r_k == c_K_LAST) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_k          <= '0;
            r_ncol       <= '0;
            r_nrow       <= '0;
            r_err        <= '0;
            r_win_en     <= 1'b0;
            r_win_din    <= '0;
            r_ctr_vld    <= 1'b0;
            r_ctr_sop    <= 1'b0;
            r_ctr_eop    <= 1'b0;
            r_ctr_border <= 1'b0;
            r_ctr_col    <= '0;
            r_ctr_row    <= '0;
        end else begin
            r_err     <= (err_clr ? 3'b000 : r_err) | {w_set_ovf, w_set_len, w_set_sop};
            r_win_en  <= w_issue;
            r_win_din <= w_accept ? din : 8'd0;
            if (w_issue) begin
                r_k <= w_kiss + KW'(1);
            end
            r_ctr_vld    <= w_cvld;
            r_ctr_sop    <= w_cvld & (r_ncol == '0) & (r_nrow == '0);
            r_ctr_eop    <= w_cvld & (r_ncol == c_COL_LAST) & (r_nrow == c_ROW_LAST);
            r_ctr_border <= w_cvld & ((r_ncol == '0) | (r_ncol == c_COL_LAST) |
                                      (r_nrow == '0) | (r_nrow == c_ROW_LAST));
            if (w_accept & din_sop) begin
                r_ncol <= '0;
                r_nrow <= '0;
            end else if (w_cvld) begin
                r_ctr_col <= r_ncol;
                r_ctr_row <= r_nrow;
                if (r_ncol == c_COL_LAST) begin
                    r_ncol <= '0;
                    r_nrow <= r_nrow + RW'(1);
                end else begin
                    r_ncol <= r_ncol + CW'(1);
                end
            end
        end
    end

    assign din_rdy    = (r_state != S_FLUSH);
    assign busy       = (r_state != S_IDLE);
    assign win_en     = r_win_en;
    assign win_din    = r_win_din;
    assign ctr_vld    = r_ctr_vld;
    assign ctr_sop    = r_ctr_sop;
    assign ctr_eop    = r_ctr_eop;
    assign ctr_border = r_ctr_border;
    assign ctr_col    = r_ctr_col;
    assign ctr_row    = r_ctr_row;
    assign err        = r_err;

endmodule

`default_nettype wire
